// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte (e.g. 0xED LED update, 0xFF reset) to a PS/2
// keyboard. The PS/2 clock and data lines are open-drain, so this block only
// produces pull-low enables. The keyboard still generates the bit clock.
// The host inhibits the clock, places the start bit and releases the clock.
// It then shifts data, odd parity and stop on successive falling clock edges
// and checks the device ack on the 11th falling edge.
//
// Ports
//   KB_CLK       in   system clock
//   SYS_RESET_N  in   asynchronous active-low reset
//   TX_DATA[7:0] in   command byte, sampled when a TX_STB is accepted
//   TX_STB       in   one-cycle start request (ignored while busy)
//   TX_BUSY      out  high from the accepted request until back in IDLE
//   TX_DONE      out  one-cycle pulse: byte sent and device ack seen
//   TX_ERR       out  one-cycle pulse: timeout or missing ack
//   PS2_CLK_IN   in   raw PS/2 clock pin (asynchronous)
//   PS2_DAT_IN   in   raw PS/2 data pin (asynchronous)
//   PS2_CLK_OE   out  1 = pull PS/2 clock low
//   PS2_DAT_OE   out  1 = pull PS/2 data low
//   CAPS         in   caps-lock state (only with PS2_TX_LED_EN)
//
// Build option
//   PS2_TX_LED_EN : adds the CAPS port and an LED sequencer. Any CAPS edge
//                   queues the two-byte sequence 0xED, {5'b0,CAPS,2'b0}.
//
// INHIBIT_CYCLES must exceed the clock filter latency (about FILTER_LEN+3
// cycles). That way the falling edge caused by our own inhibit is seen
// before the clock is released.

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       KB_CLK,
    input  logic       SYS_RESET_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_STB,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ERR,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DAT_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DAT_OE
`ifdef PS2_TX_LED_EN
    ,
    input  logic       CAPS
`endif
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    localparam logic [CW-1:0] INH_DAT  = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAITREL} state_t;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic [8:0] frame_of(input logic [7:0] d);
        return {~^d, d};
    endfunction

    // ------------------------------------------------------------------
    // Pin synchronizers and clock glitch filter
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    // The synchronizers and filter reset to 1 because an idle PS/2 bus
    // floats high. This avoids a spurious edge right after reset.
    always_ff @(posedge KB_CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every flop samples pre-edge values, whatever the statement order.
            clk_sync <= {clk_sync[0], PS2_CLK_IN};
            dat_sync <= {dat_sync[0], PS2_DAT_IN};
            fall     <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
                fall     <= ~clk_sync[1];
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t        state;
    logic [8:0]    shreg;
    logic [3:0]    bit_n;
    logic [CW-1:0] cnt;

    logic          tmo;
    logic          nack;
    logic          abort;
    logic          released;
    logic          load;
    logic [7:0]    load_byte;

`ifdef PS2_TX_LED_EN
    logic          caps_q;
    logic          led_pend;
    logic [1:0]    led_phase;   // 0: none, 1: 0xED in flight, 2: LED byte in flight
`endif

    always_comb begin
        // NOTE: every signal is given a default first, so no path can infer a latch.
        tmo       = (cnt == TMO_LAST);
        nack      = (state == SHIFT) && fall && (bit_n == 4'd10) && dat_sync[1];
        abort     = ((state == REQ) || (state == SHIFT) || (state == WAITREL)) && (tmo || nack);
        released  = clk_sync[1] & dat_sync[1];
        load      = 1'b0;
        load_byte = TX_DATA;
        if (state == IDLE && TX_STB) begin
            load = 1'b1;
        end
`ifdef PS2_TX_LED_EN
        else if (state == IDLE && led_pend) begin
            load      = 1'b1;
            load_byte = 8'hED;
        end else if (state == WAITREL && !abort && released && led_phase == 2'd1) begin
            // The LED byte follows directly, so TX_BUSY never drops between the two bytes.
            load      = 1'b1;
            load_byte = {5'b0, CAPS, 2'b0};
        end
`endif
    end

    always_ff @(posedge KB_CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_n      <= '0;
            cnt        <= '0;
            TX_BUSY    <= 1'b0;
            TX_DONE    <= 1'b0;
            TX_ERR     <= 1'b0;
            PS2_CLK_OE <= 1'b0;
            PS2_DAT_OE <= 1'b0;
`ifdef PS2_TX_LED_EN
            caps_q     <= 1'b0;
            led_pend   <= 1'b0;
            led_phase  <= 2'd0;
`endif
        end else begin
            TX_DONE <= 1'b0;
            TX_ERR  <= 1'b0;
            if (abort) begin
                // Timeout or missing ack: release the bus and report in the same cycle.
                state      <= IDLE;
                cnt        <= '0;
                TX_BUSY    <= 1'b0;
                TX_ERR     <= 1'b1;
                PS2_CLK_OE <= 1'b0;
                PS2_DAT_OE <= 1'b0;
`ifdef PS2_TX_LED_EN
                led_pend   <= 1'b0;
                led_phase  <= 2'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
`ifdef PS2_TX_LED_EN
                        if (!TX_STB && led_pend) led_phase <= 2'd1;
`endif
                    end
                    INHIBIT: begin
                        cnt <= cnt + CW'(1);
                        // The start bit goes out during the last inhibit cycle, before the clock is released.
                        if (cnt == INH_DAT) PS2_DAT_OE <= 1'b1;
                        if (cnt == INH_LAST) begin
                            PS2_CLK_OE <= 1'b0;
                            PS2_DAT_OE <= 1'b1;
                            cnt        <= '0;
                            state      <= REQ;
                        end
                    end
                    REQ: begin
                        cnt   <= cnt + CW'(1);
                        bit_n <= '0;
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        cnt <= cnt + CW'(1);
                        if (fall) begin
                            if (bit_n != 4'd11) bit_n <= bit_n + 4'd1;
                            if (bit_n <= 4'd8) begin
                                // Falls 1..9: data LSB first, then parity.
                                PS2_DAT_OE <= ~shreg[0];
                                shreg      <= {1'b0, shreg[8:1]};
                            end else if (bit_n == 4'd9) begin
                                PS2_DAT_OE <= 1'b0;    // stop bit: release
                            end else begin
                                state <= WAITREL;      // fall 11 with ack; nack goes through abort
                            end
                        end
                    end
                    WAITREL: begin
                        cnt <= cnt + CW'(1);
                        if (released) begin
                            TX_DONE <= 1'b1;
                            TX_BUSY <= 1'b0;
                            state   <= IDLE;
`ifdef PS2_TX_LED_EN
                            if (led_phase == 2'd1) begin
                                led_phase <= 2'd2;
                            end else if (led_phase == 2'd2) begin
                                led_phase <= 2'd0;
                                led_pend  <= 1'b0;
                            end
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (load) begin
                    shreg      <= frame_of(load_byte);
                    cnt        <= '0;
                    bit_n      <= '0;
                    TX_BUSY    <= 1'b1;
                    PS2_CLK_OE <= 1'b1;
                    PS2_DAT_OE <= 1'b0;
                    state      <= INHIBIT;
                end
            end
`ifdef PS2_TX_LED_EN
            // Placed last so that a CAPS edge re-arms the sequence even while it is being cleared.
            caps_q <= CAPS;
            if (CAPS != caps_q) led_pend <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx.
// A device model clocks frames out of the host over modelled open-drain lines.
// Captured frames are compared with frames built from the byte value,
// its ones count and fixed start/stop bits.
// It also exercises nack, timeout, re-request while busy and mid-frame reset.

module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int FLT  = 2;
    localparam int HALF = 20;   // device clock half period (40-cycle bit period)

    logic       KB_CLK      = 1'b0;
    logic       SYS_RESET_N = 1'b1;
    logic       TX_STB      = 1'b0;
    logic [7:0] TX_DATA     = 8'h00;
    logic       TX_BUSY;
    logic       TX_DONE;
    logic       TX_ERR;
    logic       PS2_CLK_OE;
    logic       PS2_DAT_OE;
`ifdef PS2_TX_LED_EN
    logic       CAPS = 1'b0;
`endif

    // Device side of the open-drain bus: 1 = released.
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic ps2_clk;
    logic ps2_dat;
    assign ps2_clk = dev_clk & ~PS2_CLK_OE;
    assign ps2_dat = dev_dat & ~PS2_DAT_OE;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .KB_CLK     (KB_CLK),
        .SYS_RESET_N(SYS_RESET_N),
        .TX_DATA    (TX_DATA),
        .TX_STB     (TX_STB),
        .TX_BUSY    (TX_BUSY),
        .TX_DONE    (TX_DONE),
        .TX_ERR     (TX_ERR),
        .PS2_CLK_IN (ps2_clk),
        .PS2_DAT_IN (ps2_dat),
        .PS2_CLK_OE (PS2_CLK_OE),
        .PS2_DAT_OE (PS2_DAT_OE)
`ifdef PS2_TX_LED_EN
        ,
        .CAPS       (CAPS)
`endif
    );

    always #5 KB_CLK = ~KB_CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   both_cnt  = 0;
    int   busy_fall = 0;
    logic busy_q    = 1'b0;
    always @(negedge KB_CLK) begin
        if (TX_DONE === 1'b1) done_cnt++;
        if (TX_ERR === 1'b1) err_cnt++;
        if (TX_DONE === 1'b1 && TX_ERR === 1'b1) both_cnt++;
        if (busy_q === 1'b1 && TX_BUSY === 1'b0) busy_fall++;
        busy_q = TX_BUSY;
    end

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones;
        logic par;
        ones = $countones(d);
        par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    // Device model: waits for the request state and clocks out 11 bits.
    // It samples the bus on each rising edge and drives the ack before fall 11.
    // abort_at > 0 stops it right after that falling edge (clock left low).
    // restb_at > 0 re-pulses TX_STB with inverted data right after that falling edge.
    task automatic dev_rx(input bit ack, input int abort_at, input int restb_at,
                          output logic [10:0] frame, output bit seen);
        frame = 'x;
        seen  = 1'b0;
        for (int i = 0; i < 4 * INH + 100 && !seen; i++) begin
            @(negedge KB_CLK);
            if (ps2_clk === 1'b1 && ps2_dat === 1'b0) seen = 1'b1;
        end
        if (!seen) return;
        frame[0] = ps2_dat;
        repeat (HALF) @(negedge KB_CLK);
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            if (i == abort_at) return;
            for (int c = 0; c < HALF; c++) begin
                TX_STB = (i == restb_at && c == 0);
                if (TX_STB) TX_DATA = ~TX_DATA;
                @(negedge KB_CLK);
            end
            TX_STB  = 1'b0;
            dev_clk = 1'b1;
            if (i <= 10) frame[4'(i)] = ps2_dat;
            if (i == 10 && ack) dev_dat = 1'b0;
            repeat (HALF) @(negedge KB_CLK);
        end
        dev_dat = 1'b1;
    endtask

    task automatic pulse_stb(input logic [7:0] d);
        @(negedge KB_CLK);
        TX_DATA = d;
        TX_STB  = 1'b1;
        @(negedge KB_CLK);
        TX_STB  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (TX_BUSY !== 1'b0 && k < 400) begin
            @(negedge KB_CLK);
            k++;
        end
        check({tag, "_idle_in_time"}, 32'(TX_BUSY === 1'b0), 32'd1);
        repeat (2) @(negedge KB_CLK);
    endtask

    // One full transfer with the device model, checking frame and outcome.
    task automatic xfer(input logic [7:0] d, input bit ack, input int restb_at, input string tag);
        logic [10:0] fr;
        bit          seen;
        int          d0;
        int          e0;
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_stb(d);
        check({tag, "_busy_rise"}, 32'(TX_BUSY), 32'd1);
        dev_rx(ack, 0, restb_at, fr, seen);
        check({tag, "_req_seen"}, 32'(seen), 32'd1);
        check({tag, "_frame"}, 32'(fr), 32'(model_frame(d)));
        wait_idle(tag);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        check({tag, "_err_pulses"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        check({tag, "_oe_released"}, {30'd0, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr;
        logic [7:0]  d;
        bit          seen;
        int          d0;
        int          e0;
        int          hi;
        int          k;

        // Reset state
        #2 SYS_RESET_N = 1'b0;
        repeat (3) @(negedge KB_CLK);
        check("rst_busy",   32'(TX_BUSY),    32'd0);
        check("rst_done",   32'(TX_DONE),    32'd0);
        check("rst_err",    32'(TX_ERR),     32'd0);
        check("rst_clk_oe", 32'(PS2_CLK_OE), 32'd0);
        check("rst_dat_oe", 32'(PS2_DAT_OE), 32'd0);
        SYS_RESET_N = 1'b1;
        repeat (5) @(negedge KB_CLK);

        // 1. LED command byte
        xfer(8'hED, 1'b1, 0, "ed");
        // 2. Parity extremes
        xfer(8'h01, 1'b1, 0, "x01");
        xfer(8'h00, 1'b1, 0, "x00");
        xfer(8'hFF, 1'b1, 0, "xff");
        // Random bytes
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            xfer(d, 1'b1, 0, $sformatf("rnd%0d", i));
        end

        // 3. Missing ack
        xfer(8'($urandom), 1'b0, 0, "nack");

        // 4. Device never clocks: inhibit length and timeout
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_stb(8'hFF);
        hi = 0;
        while (PS2_CLK_OE === 1'b1 && hi < 100) begin
            hi++;
            @(negedge KB_CLK);
        end
        check("inhibit_len", 32'(hi), 32'(INH));
        check("req_dat_oe", 32'(PS2_DAT_OE), 32'd1);
        k = 0;
        while (TX_ERR !== 1'b1 && k < TMO + 100) begin
            @(negedge KB_CLK);
            k++;
        end
        check("timeout_len", 32'(k), 32'(TMO));
        check("timeout_busy", 32'(TX_BUSY), 32'd0);
        check("timeout_oe", {30'd0, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
        repeat (3) @(negedge KB_CLK);
        check("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("timeout_done_pulses", 32'(done_cnt - d0), 32'd0);

        // 5a. TX_STB re-pulsed mid-frame is ignored
        xfer(8'($urandom), 1'b1, 3, "restb");

        // 5b. Reset at bit 5
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_stb(8'h00);
        dev_rx(1'b1, 5, 0, fr, seen);
        check("rst5_req_seen", 32'(seen), 32'd1);
        repeat (10) @(negedge KB_CLK);
        check("rst5_busy_before", 32'(TX_BUSY), 32'd1);
        check("rst5_dat_oe_before", 32'(PS2_DAT_OE), 32'd1);
        SYS_RESET_N = 1'b0;
        #1;
        check("rst5_oe", {30'd0, PS2_CLK_OE, PS2_DAT_OE}, 32'd0);
        check("rst5_busy", 32'(TX_BUSY), 32'd0);
        dev_clk = 1'b1;
        @(negedge KB_CLK);
        SYS_RESET_N = 1'b1;
        repeat (5) @(negedge KB_CLK);
        check("rst5_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // Still functional after reset
        xfer(8'($urandom), 1'b1, 0, "post_rst");

`ifdef PS2_TX_LED_EN
        // 6. CAPS edges drive the two-byte LED sequence
        for (int e = 0; e < 2; e++) begin
            logic [10:0] f1;
            logic [10:0] f2;
            bit          s1;
            bit          s2;
            int          bf0;
            bf0 = busy_fall;
            d0  = done_cnt;
            @(negedge KB_CLK);
            CAPS = (e == 0);
            dev_rx(1'b1, 0, 0, f1, s1);
            dev_rx(1'b1, 0, 0, f2, s2);
            wait_idle("led");
            check("led_seen", 32'({s1, s2}), 32'd3);
            check("led_byte1", 32'(f1), 32'(model_frame(8'hED)));
            check("led_byte2", 32'(f2), 32'(model_frame(e == 0 ? 8'h04 : 8'h00)));
            check("led_done_pulses", 32'(done_cnt - d0), 32'd2);
            check("led_busy_falls", 32'(busy_fall - bf0), 32'd1);
        end
`endif

        check("done_err_exclusive", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
